fetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of the instruction decoder (control unit). Maintains the program counter and issues reads to a synchronous-read instruction memory. Buffers returned 21-bit instruction words in a small FIFO and presents them to decode over a valid/ready handshake. Supports PC redirect (jump/flush) and stops on a HALT opcode.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/fetch_fifo.sv | 86 ++++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the front end of the CPU: instruction width, field
// positions inside a 21-bit instruction word, opcode constants and a helper
// that recognises the HALT opcode.
// Layout: opcode [20:17], op1 [16:14], op2 [13:11], op3 [10:8], imm [7:0].
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int INSTR_W    = 21;
   localparam int DEF_ADDR_W = 8;

   localparam int OPC_HI = 20;
   localparam int OPC_LO = 17;
   localparam int OP1_HI = 16;
   localparam int OP1_LO = 14;
   localparam int OP2_HI = 13;
   localparam int OP2_LO = 11;
   localparam int OP3_HI = 10;
   localparam int OP3_LO = 8;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   typedef enum logic [3:0] {
      OPC_NOP    = 4'h0,
      OPC_ALU    = 4'h1,
      OPC_LOAD   = 4'h2,
      OPC_STORE  = 4'h3,
      OPC_BRANCH = 4'h4,
      OPC_JUMP   = 4'h5,
      OPC_HALT   = 4'hF
   } opcode_e;

   typedef struct packed {
      logic [3:0] opc;
      logic [2:0] op1;
      logic [2:0] op2;
      logic [2:0] op3;
      logic [7:0] imm;
   } instr_t;

   // True when the word carries the HALT opcode.
   function automatic logic isHalt(input logic [INSTR_W-1:0] word);
      return word[OPC_HI:OPC_LO] == OPC_HALT;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {pc, instruction} entries between
// the fetch logic and decode.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        drop all entries (takes priority over push)
//   push_i, data_i write an entry
//   pop_i          remove head entry (ignored when empty)
//   valid_o        head entry present
//   data_o         head entry, zero while empty
//   count_o        number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 29,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W-1:0] wrPtr_q;
   logic [CNT_W-1:0] count_q;
   logic             doPush;
   logic             doPop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A push into a full FIFO is only accepted when the head leaves in the
   // same cycle.
   always_comb begin
      doPop  = pop_i && (count_q != '0);
      doPush = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= nextPtr(wrPtr_q);
         end
         if (doPop) begin
            rdPtr_q <= nextPtr(rdPtr_q);
         end
         if (doPush && !doPop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (doPop && !doPush) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // Storage array needs no reset; stale contents are hidden by valid_o.
   always_ff @(posedge clk_i) begin
      if (doPush && !clear_i && !rst_i) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // Head is forced to zero while empty so decode never sees stale words.
   always_comb begin
      valid_o = (count_q != '0);
      data_o  = valid_o ? mem_q[rdPtr_q] : '0;
      count_o = count_q;
   end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of decode. Keeps the PC, issues reads to a
// synchronous-read instruction memory, buffers returned words in fetch_fifo
// and hands them to decode over valid/ready. Supports redirect and HALT.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   run                             fetch enable for new reads
//   imem_en, imem_addr, imem_data   memory read strobe / address / data
//   redirect_valid, redirect_pc     flush and restart at a new PC
//   instr_valid, instr_ready        decode handshake
//   instr, instr_pc                 head word and its address
//   halted                          HALT seen, fetch stopped
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int ADDR_W  = cpu_pkg::DEF_ADDR_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               halted
);

   import cpu_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;
   localparam int ENT_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pendingPc_q, pendingPc_d;
   logic              pending_q, pending_d;
   logic              halted_q, halted_d;

   logic [CNT_W-1:0]  fifoCount;
   logic              fifoValid;
   logic [ENT_W-1:0]  headEntry;
   logic              issue;
   logic              retHalt;
   logic              push;
   logic              pop;

   // Issue decision looks only at registered occupancy plus the in-flight
   // read, so decode's ready never reaches the memory strobe and the FIFO
   // always has room for every outstanding return.
   always_comb begin
      issue = run && !halted_q && !rst && !redirect_valid &&
              ((SUM_W'(fifoCount) + SUM_W'(pending_q)) < SUM_W'(DEPTH));
      retHalt = pending_q && isHalt(imem_data);
      push    = pending_q && !retHalt;
      pop     = fifoValid && instr_ready;
   end

   // Next-state for PC, in-flight read and halt flag. A HALT return rewinds
   // the PC to the HALT word and drops any read issued alongside it.
   always_comb begin
      pc_d        = pc_q;
      pending_d   = 1'b0;
      pendingPc_d = pendingPc_q;
      halted_d    = halted_q;
      if (redirect_valid) begin
         pc_d     = redirect_pc;
         halted_d = 1'b0;
      end else begin
         if (issue) begin
            pc_d        = pc_q + ADDR_W'(1);
            pending_d   = 1'b1;
            pendingPc_d = pc_q;
         end
         if (retHalt) begin
            pc_d      = pendingPc_q;
            pending_d = 1'b0;
            halted_d  = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= '0;
         pendingPc_q <= '0;
         pending_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         pendingPc_q <= pendingPc_d;
         pending_q   <= pending_d;
         halted_q    <= halted_d;
      end
   end

   // Redirect clears the buffer, which also discards a same-cycle return.
   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .CNT_W (CNT_W)
   ) uFifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (redirect_valid),
      .push_i  (push),
      .data_i  ({pendingPc_q, imem_data}),
      .pop_i   (pop),
      .valid_o (fifoValid),
      .data_o  (headEntry),
      .count_o (fifoCount)
   );

   // Outputs.
   always_comb begin
      imem_en     = issue;
      imem_addr   = pc_q;
      instr_valid = fifoValid;
      instr_pc    = headEntry[ENT_W-1:INSTR_W];
      instr       = headEntry[INSTR_W-1:0];
      halted      = halted_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: a cycle table for the start-up
// pipeline, a scoreboard of expected instruction addresses popped on every
// decode handshake, and hand-written sequences for stall, redirect, reset,
// HALT and PC wrap.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   import cpu_pkg::*;

   localparam int AW = 8;
   localparam int IW = 21;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data = '0;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic [IW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          halted;

   logic [IW-1:0] mem [256];
   logic [AW-1:0] expQ [$];
   int            vecCount = 0;
   int            missCount = 0;
   int            hsCount = 0;

   typedef struct {
      logic          run;
      logic          ready;
      logic          expEn;
      logic [AW-1:0] expAddr;
      logic          expValid;
      logic [AW-1:0] expPc;
   } vec_t;

   vec_t tbl [6];

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .halted         (halted)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Synchronous-read instruction memory: data appears the cycle after the read.
   always @(posedge clk) begin
      if (imem_en) begin
         imem_data <= mem[imem_addr];
      end
   end

   // Non-HALT word whose contents identify its address.
   function automatic logic [IW-1:0] aluWord(input int a);
      logic [3:0] opc;
      opc = 4'h1;
      return {opc, 9'(a * 3), 8'(a)};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushRange(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back(AW'(first + i));
      end
   endtask

   // Scores a handshake if one happens at the coming edge, then advances to
   // 1 time unit after that edge where the next cycle's inputs are driven.
   task automatic applyStimulus();
      logic [AW-1:0] e;
      if (instr_valid && instr_ready) begin
         hsCount++;
         if (expQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL unexpected_word: got pc %0h, required none", instr_pc);
         end else begin
            e = expQ.pop_front();
            checkOutput("instr_pc", 32'(instr_pc), 32'(e));
            checkOutput("instr", 32'(instr), 32'(mem[e]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Accept words while the scoreboard still expects some, bounded.
   task automatic drain(input int maxCycles);
      int n;
      n = 0;
      while (expQ.size() > 0 && n < maxCycles) begin
         instr_ready = 1'b1;
         #2;
         applyStimulus();
         n++;
      end
      instr_ready = 1'b0;
      checkOutput("drain_left", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 8'd0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 8'd1};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 8'd2};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 8'd3};

      for (int a = 0; a < 256; a++) begin
         mem[a] = aluWord(a);
      end

      rst            = 1'b1;
      run            = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, with run already high to show reset blocks issue.
      run         = 1'b1;
      instr_ready = 1'b1;
      #2;
      checkOutput("rst_imem_en", 32'(imem_en), 32'd0);
      checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_instr", 32'(instr), 32'd0);
      checkOutput("rst_instr_pc", 32'(instr_pc), 32'd0);
      checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
      applyStimulus();

      // Start-up pipeline: reads 0..5 back to back, words from cycle 2.
      rst = 1'b0;
      pushRange(0, 4);
      for (int k = 0; k < 6; k++) begin
         run         = tbl[k].run;
         instr_ready = tbl[k].ready;
         #2;
         checkOutput("tbl_imem_en", 32'(imem_en), 32'(tbl[k].expEn));
         checkOutput("tbl_imem_addr", 32'(imem_addr), 32'(tbl[k].expAddr));
         checkOutput("tbl_instr_valid", 32'(instr_valid), 32'(tbl[k].expValid));
         checkOutput("tbl_instr_pc", 32'(instr_pc), 32'(tbl[k].expPc));
         if (!tbl[k].expValid) begin
            checkOutput("tbl_instr_empty", 32'(instr), 32'd0);
         end
         applyStimulus();
      end

      // Decode stalls 6 cycles: head held, two more reads, then fetch stops.
      pushRange(4, 11);
      for (int i = 0; i < 6; i++) begin
         instr_ready = 1'b0;
         #2;
         checkOutput("stall_valid", 32'(instr_valid), 32'd1);
         checkOutput("stall_pc", 32'(instr_pc), 32'd4);
         checkOutput("stall_imem_en", 32'(imem_en), (i < 2) ? 32'd1 : 32'd0);
         applyStimulus();
      end

      // Release: one word per cycle with no bubble.
      hsCount = 0;
      for (int i = 0; i < 10; i++) begin
         instr_ready = 1'b1;
         #2;
         if (i == 0) begin
            checkOutput("full_no_issue", 32'(imem_en), 32'd0);
         end
         applyStimulus();
      end
      checkOutput("throughput", 32'(hsCount), 32'd10);

      // Redirect with two buffered words and one read in flight; the
      // handshake on word 14 in the same cycle still completes.
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      instr_ready    = 1'b1;
      #2;
      checkOutput("redir_no_issue", 32'(imem_en), 32'd0);
      checkOutput("redir_head", 32'(instr_pc), 32'd14);
      applyStimulus();
      redirect_valid = 1'b0;
      #2;
      checkOutput("redir_q_empty", 32'(expQ.size()), 32'd0);
      checkOutput("redir_valid_r1", 32'(instr_valid), 32'd0);
      checkOutput("redir_en_r1", 32'(imem_en), 32'd1);
      checkOutput("redir_addr_r1", 32'(imem_addr), 32'h40);
      pushRange(8'h40, 4);
      applyStimulus();
      #2;
      checkOutput("redir_valid_r2", 32'(instr_valid), 32'd0);
      applyStimulus();
      #2;
      checkOutput("redir_valid_r3", 32'(instr_valid), 32'd1);
      checkOutput("redir_pc_r3", 32'(instr_pc), 32'h40);
      drain(12);

      // Let the buffer fill to three words plus one read in flight.
      applyStimulus();
      applyStimulus();
      #2;
      checkOutput("near_full_no_issue", 32'(imem_en), 32'd0);
      checkOutput("near_full_pc", 32'(instr_pc), 32'h44);

      // Reset in that state; the returning word must be dropped.
      rst = 1'b1;
      #2;
      checkOutput("rst2_imem_en", 32'(imem_en), 32'd0);
      applyStimulus();
      #2;
      checkOutput("rst2_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst2_halted", 32'(halted), 32'd0);
      checkOutput("rst2_pc", 32'(imem_addr), 32'd0);
      checkOutput("rst2_instr", 32'(instr), 32'd0);
      checkOutput("rst2_instr_pc", 32'(instr_pc), 32'd0);
      applyStimulus();

      // HALT at address 5: words 0..4 delivered, HALT never presented.
      mem[5]      = 21'h1E0000;
      rst         = 1'b0;
      instr_ready = 1'b1;
      pushRange(0, 5);
      #2;
      checkOutput("halt_start_en", 32'(imem_en), 32'd1);
      checkOutput("halt_start_addr", 32'(imem_addr), 32'd0);
      checkOutput("halt_start_valid", 32'(instr_valid), 32'd0);
      applyStimulus();
      #2;
      checkOutput("post_rst_valid", 32'(instr_valid), 32'd0);
      applyStimulus();
      drain(12);
      for (int i = 0; i < 3; i++) begin
         #2;
         checkOutput("halted", 32'(halted), 32'd1);
         checkOutput("halted_no_issue", 32'(imem_en), 32'd0);
         checkOutput("halted_pc", 32'(imem_addr), 32'd5);
         checkOutput("halted_empty", 32'(instr_valid), 32'd0);
         applyStimulus();
      end

      // Redirect out of HALT.
      redirect_valid = 1'b1;
      redirect_pc    = 8'h06;
      #2;
      checkOutput("unhalt_no_issue", 32'(imem_en), 32'd0);
      applyStimulus();
      redirect_valid = 1'b0;
      pushRange(6, 3);
      #2;
      checkOutput("unhalt_halted", 32'(halted), 32'd0);
      checkOutput("unhalt_en", 32'(imem_en), 32'd1);
      checkOutput("unhalt_addr", 32'(imem_addr), 32'd6);
      applyStimulus();
      drain(12);

      // PC wrap: 0xFE, 0xFF, 0x00, 0x01.
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFE;
      #2;
      applyStimulus();
      redirect_valid = 1'b0;
      expQ.delete();
      expQ.push_back(8'hFE);
      expQ.push_back(8'hFF);
      expQ.push_back(8'h00);
      expQ.push_back(8'h01);
      drain(12);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
